// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the enums used by the program loader.
// Opcodes are the same ones the main decoder matches on.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_IALU   = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5
  } instr_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ldr_state_t;

  // Shift-immediate forms carry funct7 in the upper immediate bits.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Pure combinational map from an instruction request to its RV32I word,
// with flags for an unknown class and an odd branch/jump offset.
module instr_field_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        misalign
);

  // Immediate bits above 20 never reach any format.
  logic unused_imm;
  assign unused_imm = ^imm[31:21];

  always_comb begin
    word     = '0;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (cls)
      CLS_R: begin
        word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
      end
      CLS_IALU: begin
        if (is_shift_f3(funct3)) begin
          word = {1'b0, f7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_IALU};
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OP_IALU};
        end
      end
      CLS_LOAD: begin
        word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      end
      CLS_STORE: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      end
      CLS_BRANCH: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        misalign = imm[0];
      end
      CLS_JAL: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        misalign = imm[0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams encoded instructions into imem through its write port, one word per
// accepted request, starting at word 0 on every start and stopping when full.
module instr_encode_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_class,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic              req_f7b5,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err_illegal,
  output logic              err_align
);

  localparam int CAP = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CAP_COUNT = CAP[ADDR_W:0];

  ldr_state_t        state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              err_illegal_reg, err_align_reg;

  logic [31:0] enc_word;
  logic        enc_illegal, enc_misalign;
  logic        accept, restart;

  instr_field_encoder u_enc (
    .cls      (req_class),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .funct3   (req_funct3),
    .f7b5     (req_f7b5),
    .imm      (req_imm),
    .word     (enc_word),
    .illegal  (enc_illegal),
    .misalign (enc_misalign)
  );

  assign full    = (count_reg == CAP_COUNT);
  assign accept  = req_valid && req_ready;
  assign restart = start && (state_reg != RUN);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    if (start)  state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state_reg == RUN);
    done      = (state_reg == DONE);
    req_ready = (state_reg == RUN) && !full;
  end

  // Counter, sticky flags and the registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg       <= '0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      err_illegal_reg <= 1'b0;
      err_align_reg   <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      if (restart) begin
        count_reg       <= '0;
        err_illegal_reg <= 1'b0;
        err_align_reg   <= 1'b0;
      end
      // accept only happens in RUN, so it never overlaps a restart
      if (accept) begin
        if (enc_illegal) begin
          err_illegal_reg <= 1'b1;
        end else begin
          we_reg    <= 1'b1;
          addr_reg  <= count_reg[ADDR_W-1:0];
          wdata_reg <= enc_word;
          count_reg <= count_reg + (ADDR_W + 1)'(1);
          if (enc_misalign) begin
            err_align_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign imem_we     = we_reg;
  assign imem_addr   = addr_reg;
  assign imem_wdata  = wdata_reg;
  assign count       = count_reg;
  assign err_illegal = err_illegal_reg;
  assign err_align   = err_align_reg;

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Producer end of the control decode path: takes structured instruction requests and writes 32-bit RV32I machine words into instruction memory.
- Each request carries an instruction class, register fields, funct3, funct7 bit 5 and an immediate. The output word is therefore exactly what the main decoder and the ALU decoder consume.
- Used by the bring-up and test harness to load programs into imem through its write port before releasing the core from stall.

Parameters:
- ADDR_W, 6, imem word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  pulse; begin a new load at word 0 (accepted in IDLE or DONE)
- finish  in  1  pulse; end the current load (accepted in RUN)
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_class  in  3  instr_class_t: R=0, IALU=1, LOAD=2, STORE=3, BRANCH=4, JAL=5; 6 and 7 are illegal
- req_rd  in  5  destination register
- req_rs1  in  5  source register 1
- req_rs2  in  5  source register 2
- req_funct3  in  3  funct3 field
- req_f7b5  in  1  funct7 bit 5 (sub/sra/srai)
- req_imm  in  32  signed immediate (byte offset for BRANCH and JAL)
- imem_we  out  1  imem write strobe
- imem_addr  out  ADDR_W  imem word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  number of words written in this load
- busy  out  1  state==RUN
- done  out  1  state==DONE
- full  out  1  count == 2**ADDR_W
- err_illegal  out  1  sticky: an illegal class was seen
- err_align  out  1  sticky: req_imm[0]=1 on BRANCH or JAL

Behaviour:
- Reset is asynchronous. During and after reset:
  - state=IDLE
  - count=0
  - imem_we=0, imem_addr=0, imem_wdata=0
  - err_illegal=0, err_align=0
  - req_ready=0
- FSM:
  - IDLE -(start)-> RUN
  - RUN -(finish)-> DONE
  - DONE -(start)-> RUN
  - Entering RUN from start clears count and both err flags.
  - start is ignored while in RUN. finish is ignored outside RUN.
- req_ready = (state==RUN) && !full. It is combinational and never depends on req_valid.
- Accept cycle for a legal class:
  - The next edge registers imem_we=1, imem_addr=count[ADDR_W-1:0] and imem_wdata=encode(req).
  - count increments on the same edge.
  - Write latency is 1 cycle. Throughput is 1 word per cycle.
- imem_we is high for exactly one cycle per legal accepted request and is 0 otherwise. imem_addr and imem_wdata hold their last values when imem_we=0.
- Illegal class: the request is consumed, nothing is written, count is unchanged, and err_illegal is set.
- BRANCH or JAL with imm[0]=1: the word is still written with imm[0] ignored, and err_align is set.
- finish and an accepted request in the same cycle: the request is written, then the FSM enters DONE.
- full: once count reaches 2**ADDR_W, req_ready drops. count never wraps, and no write happens to address 0 again.
- Reset mid-write aborts the load. Any pending imem_we is cleared immediately (asynchronously).
- Encoding (only the listed imm bits are used; upper bits are silently truncated):
  - R: {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011}
  - IALU:
    - f3 = 001 or 101: {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011}
    - other f3: {imm[11:0], rs1, f3, rd, 7'b0010011}
  - LOAD: {imm[11:0], rs1, f3, rd, 7'b0000011}
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}

Decomposition:
- riscv_pkg holds:
  - opcode localparams OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, shared with Main_Decoder
  - instr_class_t enum
  - ldr_state_t enum {IDLE, RUN, DONE}
- One combinational sub-module, instr_field_encoder: maps class, fields and imm to word, plus illegal and misalign flags. It is unit-testable against the decoder.
- The FSM, counter and output registers live in instr_encode_loader.

Test Plan:
- Reset, then start, then one request each for add x3,x1,x2 / addi x1,x0,5 / lw x2,8(x1) / sw x2,4(x1) at consecutive cycles -> imem words 0..3 are 0x002081B3, 0x00500093, 0x0080A103, 0x0020A223; imem_we high 4 consecutive cycles, each 1 cycle after acceptance; count=4.
- beq x1,x2,-4 (imm=0xFFFFFFFC) then jal x1,8 -> 0xFE208EE3, 0x008000EF; feed each word back through Main_Decoder and check branch=1 and jump=1 respectively.
- ADDR_W=2, 6 back-to-back requests -> 4 writes at addresses 0..3; full=1 and req_ready=0 from the cycle after the 4th accept; count stays 4.
- req_class=6, then BRANCH with imm=3 -> first: no write, err_illegal=1, count unchanged; second: word written with imm[0] dropped, err_align=1; both flags clear on the next start.
- finish asserted in the same cycle as an accepted request -> that word is written, done=1 next cycle; further requests see req_ready=0; start returns to RUN with count=0.
- reset asserted asynchronously mid-cycle while imem_we=1 -> imem_we, count and state clear without waiting for clk; no further writes until start.
